// File: rtl/mem_responder.sv
// mem_responder: unified RAM plus MMIO (console FIFO, LEDs, sticky errors, cycle counter; counter gated by MEM_RESPONDER_CYCLE_COUNTER_EN)
module mem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter string       INIT_FILE   = "program.hex",
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000,
  parameter int          TXQ_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic [3:0]  WriteMask,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  leds,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(TXQ_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  logic [31:0] mem [DEPTH_WORDS];
  logic [7:0] txq [TXQ_DEPTH];
  logic [31:0] rdata_q, rdata_d, mmio_rd, cyc_lo, cyc_hi;
  logic [7:0] leds_q, leds_d;
  logic [1:0] err_q, err_d, err_clr;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0] fill_q, fill_d;
  logic ram_hit, mmio_hit, bad_addr, wr_lane0, push_req, push, pop, full, ovf;
  logic [2:0] reg_sel;
  logic [AW-1:0] widx;
  assign ram_hit  = Address < RAM_BYTES;
  assign mmio_hit = (Address & ~32'h1F) == MMIO_BASE;
  assign bad_addr = !ram_hit && !mmio_hit;
  assign reg_sel  = Address[4:2];
  assign widx     = Address[AW+1:2];
  assign wr_lane0 = MemWrite && mmio_hit && WriteMask[0];
  assign push_req = wr_lane0 && reg_sel == 3'd0;
  assign full     = fill_q == (PW+1)'(TXQ_DEPTH);
  assign tx_valid = fill_q != '0;
  assign tx_data  = tx_valid ? txq[rd_q] : 8'd0;
  assign pop      = tx_valid && tx_ready;
  assign push     = push_req && (!full || pop);
  assign ovf      = push_req && full && !pop;
  assign err_clr  = (wr_lane0 && reg_sel == 3'd3) ? WriteData[1:0] : 2'b00;
  assign ReadData = rdata_q;
  assign leds     = leds_q;
  assign err      = |err_q;
`ifdef MEM_RESPONDER_CYCLE_COUNTER_EN
  logic [63:0] cyc_q, cyc_d;
  logic [31:0] hi_q, hi_d;
  assign cyc_lo = cyc_q[31:0];
  assign cyc_hi = hi_q;
  always_comb begin
    cyc_d = cyc_q + 64'd1;
    hi_d  = (mmio_hit && reg_sel == 3'd4) ? cyc_q[63:32] : hi_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      hi_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      hi_q  <= hi_d;
    end
  end
`else
  assign cyc_lo = 32'd0;
  assign cyc_hi = 32'd0;
`endif
  assign mmio_rd = reg_sel == 3'd1 ? {16'd0, 8'(fill_q), 6'd0, !tx_valid, full} :
                   reg_sel == 3'd2 ? {24'd0, leds_q} :
                   reg_sel == 3'd3 ? {30'd0, err_q} :
                   reg_sel == 3'd4 ? cyc_lo :
                   reg_sel == 3'd5 ? cyc_hi : 32'd0;
  always_comb begin
    rdata_d = ram_hit ? mem[widx] : mmio_hit ? mmio_rd : 32'd0;
    leds_d  = (wr_lane0 && reg_sel == 3'd2) ? WriteData[7:0] : leds_q;
    err_d   = (err_q & ~err_clr) | {ovf, bad_addr};
    rd_d    = rd_q + PW'(pop);
    wr_d    = wr_q + PW'(push);
    fill_d  = fill_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      leds_q  <= '0;
      err_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      fill_q  <= '0;
    end else begin
      rdata_q <= rdata_d;
      leds_q  <= leds_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fill_q  <= fill_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (MemWrite && ram_hit && WriteMask[i]) mem[widx][8*i +: 8] <= WriteData[8*i +: 8];
    if (push) txq[wr_q] <= WriteData[7:0];
  end
endmodule
